// File: rtl/tdm_demux_1x8.sv
// 1-to-8 TDM demultiplexer: hunts for frame_sync, then deserialises one bit per valid slot.
// Optional TDM_PARITY_EN adds a ninth even-parity slot and the parity_err output.
module tdm_demux_1x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       locked,
  output logic       sync_err
`ifdef TDM_PARITY_EN
  ,
  output logic       parity_err
`endif
);

`ifdef TDM_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;
  localparam int         SHW       = 8;
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
  localparam int         SHW       = 7;
`endif

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SHW-1:0]   shadow_q, shadow_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
`ifdef TDM_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
`ifdef TDM_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          state_d     = LOCK;
          shadow_d    = '0;
          shadow_d[0] = din;
          cnt_d       = 4'd1;
        end
      end else if (frame_sync && cnt_q != 4'd0) begin
        // Misplaced sync: drop the partial frame and restart at slot 0.
        sync_err_d  = 1'b1;
        shadow_d    = '0;
        shadow_d[0] = din;
        cnt_d       = 4'd1;
      end else begin
        for (int i = 0; i < SHW; i++)
          if (cnt_q == i[3:0]) shadow_d[i] = din;
        if (cnt_q == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
          dout_d       = shadow_q;
          parity_err_d = ^{din, shadow_q};
`else
          dout_d       = {din, shadow_q};
`endif
          dout_valid_d = 1'b1;
          cnt_d        = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
`ifdef TDM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
`ifdef TDM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Scoreboard bench for tdm_demux_1x8: stimulus pushes expected frames/sync errors,
// a negedge monitor pops and checks whenever the DUT pulses an output.
module tb_tdm_demux_1x8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, frame_sync = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, locked, sync_err;
`ifdef TDM_PARITY_EN
  logic       parity_err;
`endif

  tdm_demux_1x8 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout), .dout_valid(dout_valid), .locked(locked), .sync_err(sync_err)
`ifdef TDM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    logic       perr;
  } exp_t;

  exp_t frame_q[$];
  int   sync_q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_dv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue, at the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dout_valid) begin
          check("dv_not_back_to_back", {31'b0, prev_dv}, 32'd0);
          if (frame_q.size() == 0) check("unexpected_dout_valid", 32'd1, 32'd0);
          else begin
            e = frame_q.pop_front();
            check("dout", {24'b0, dout}, {24'b0, e.data});
            check("dout_valid_cycle", cyc, e.cyc);
`ifdef TDM_PARITY_EN
            check("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
`endif
          end
        end
`ifdef TDM_PARITY_EN
        else if (parity_err) check("parity_err_without_dv", 32'd1, 32'd0);
`endif
        if (sync_err) begin
          if (sync_q.size() == 0) check("unexpected_sync_err", 32'd1, 32'd0);
          else check("sync_err_cycle", cyc, sync_q.pop_front());
        end
        prev_dv = dout_valid;
      end
    end
  end

  task automatic send_bit(input logic d, input logic fs);
    @(negedge clk);
    din = d; din_valid = 1'b1; frame_sync = fs;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0; frame_sync = 1'b0; din = 1'b1;
    end
  endtask

  // Slot i carries data[i]; gap of gap_len idle cycles inserted after slot gap_after.
  task automatic send_frame(input logic [7:0] data, input logic fs, input logic exp_sync,
                            input int gap_after, input int gap_len, input logic flip_par);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], fs && i == 0);
      if (i == 0 && exp_sync) sync_q.push_back(last_cyc + 1);
      if (i == gap_after) idle(gap_len);
    end
`ifdef TDM_PARITY_EN
    send_bit(^data ^ flip_par, 1'b0);
`endif
    e.data = data; e.cyc = last_cyc + 1; e.perr = flip_par;
    frame_q.push_back(e);
  endtask

  initial begin
    logic [7:0] pat;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", {24'b0, dout}, 32'h00);
    check("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_sync_err", {31'b0, sync_err}, 32'd0);
`ifdef TDM_PARITY_EN
    check("rst_parity_err", {31'b0, parity_err}, 32'd0);
`endif
    rst = 1'b0;

    // Valid bits with no frame_sync are discarded
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    idle(2);
    check("hunt_locked", {31'b0, locked}, 32'd0);
    check("hunt_dout", {24'b0, dout}, 32'h00);

    // Basic frame 1,0,1,1,0,0,1,0 -> 8'h4D; locked from the cycle after the first bit
    pat = 8'h4D;
    send_bit(pat[0], 1'b1);
    send_bit(pat[1], 1'b0);
    check("locked_after_first", {31'b0, locked}, 32'd1);
    for (int i = 2; i < 8; i++) send_bit(pat[i], 1'b0);
`ifdef TDM_PARITY_EN
    send_bit(^pat, 1'b0);
`endif
    frame_q.push_back('{data: 8'h4D, cyc: last_cyc + 1, perr: 1'b0});
    idle(3);
    check("dout_hold_4d", {24'b0, dout}, 32'h4D);

    // Back-to-back frames, optional slot-0 sync absent on the second
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1, 0, 1'b0);
    idle(2);
    check("locked_b2b", {31'b0, locked}, 32'd1);

    // Gap of 3 idle cycles between slots 3 and 4
    send_frame(8'h96, 1'b0, 1'b0, 3, 3, 1'b0);
    idle(2);

    // Misplaced sync at slot 5: partial frame dropped, sync bit starts a new frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_frame(8'h5B, 1'b1, 1'b1, -1, 0, 1'b0);
    idle(2);
    check("locked_after_sync_err", {31'b0, locked}, 32'd1);

`ifdef TDM_PARITY_EN
    // Bad parity then good parity on frame 8'h01
    send_frame(8'h01, 1'b0, 1'b0, -1, 0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, -1, 0, 1'b0);
    idle(2);
`endif

    // Reset mid-frame discards the partial frame and requires a new sync
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst_locked", {31'b0, locked}, 32'd0);
    check("midrst_dout", {24'b0, dout}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    idle(2);
    check("postrst_locked", {31'b0, locked}, 32'd0);
    check("postrst_dout", {24'b0, dout}, 32'h00);
    send_frame(8'hC3, 1'b1, 1'b0, -1, 0, 1'b0);
    idle(4);
    check("final_dout", {24'b0, dout}, 32'hC3);

    check("frames_outstanding", frame_q.size(), 32'd0);
    check("syncs_outstanding", sync_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/tdm_demux_1x8.md
TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 channels, 1 bit per channel per frame.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  1  serial TDM data bit for the current slot.
REQ-005 din_valid  input  1  qualifies din and frame_sync; no state advances when low.
REQ-006 frame_sync  input  1  marks the current valid bit as slot 0; ignored when din_valid=0.
REQ-007 dout  output  8  demultiplexed frame; dout[i] = bit received in slot i.
REQ-008 dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-009 locked  output  1  high while the FSM is in LOCK.
REQ-010 sync_err  output  1  one-cycle pulse on misplaced frame_sync.
REQ-011 parity_err  output  1  present only when TDM_PARITY_EN is defined (see Configuration).

Function
REQ-012 The FSM SHALL have two states: HUNT and LOCK.
REQ-013 In HUNT, valid bits without frame_sync SHALL be discarded; slot counter held at 0.
REQ-014 HUNT -> LOCK on din_valid&frame_sync; that din SHALL be stored as slot 0 and the counter set to 1.
REQ-015 In LOCK, each valid bit SHALL be stored into a shadow register at index slot, and the counter SHALL increment, wrapping from the last slot to 0.
REQ-016 In LOCK, frame_sync at slot 0 is optional; its absence SHALL NOT cause loss of lock.
REQ-017 In LOCK, frame_sync at slot k != 0: sync_err SHALL pulse the next cycle, the partial frame SHALL be discarded (no dout_valid), din SHALL be stored as slot 0, and the counter SHALL become 1; the FSM stays in LOCK.
REQ-018 On the valid bit in the last slot, dout SHALL load {din, shadow[6:0]} and dout_valid SHALL be 1 in the following cycle only (latency: 1 clock after the last bit).
REQ-019 dout SHALL hold its value between updates; dout_valid SHALL never be high for two consecutive cycles.
REQ-020 din_valid low for any number of cycles SHALL freeze counter, shadow and FSM state.
REQ-021 locked SHALL equal (state == LOCK), registered.

Reset
REQ-022 While rst=1: state=HUNT, counter=0, shadow=0, dout=8'h00, dout_valid=0, locked=0, sync_err=0, parity_err=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame immediately; after release, the block SHALL require a new frame_sync before producing output.

Configuration
REQ-024 Macro TDM_PARITY_EN: when defined, each frame SHALL be 9 slots; slot 8 carries even parity over slots 0-7.
REQ-025 With TDM_PARITY_EN, dout/dout_valid SHALL update one cycle after slot 8; parity_err SHALL pulse in the same cycle as dout_valid if the XOR of slots 0-8 is 1; dout is updated regardless.
REQ-026 Without TDM_PARITY_EN, frames SHALL be 8 slots, the counter wraps from 7 to 0, and the parity_err port and logic SHALL be absent.

Verification
REQ-027 Reset then 8 valid bits 1,0,1,1,0,0,1,0 with frame_sync on the first -> dout=8'h4D, dout_valid high exactly 1 cycle after the 8th bit, locked=1 from the cycle after the first bit.
REQ-028 5 valid bits without frame_sync after reset -> no dout_valid, locked=0, dout=8'h00.
REQ-029 Two back-to-back frames 8'hA5 then 8'h3C, frame_sync only on the first -> dout_valid pulses twice, dout=8'hA5 then 8'h3C.
REQ-030 Frame with din_valid deasserted for 3 cycles between slots 3 and 4 -> same dout as the gap-free case, dout_valid delayed by 3 cycles.
REQ-031 frame_sync asserted at slot 5 while locked -> sync_err pulse, no dout_valid for the partial frame, next 8 bits form a complete frame.
REQ-032 TDM_PARITY_EN defined, frame 8'h01 with parity bit 0 -> dout=8'h01, dout_valid=1, parity_err=1 in the same cycle; with parity bit 1 -> parity_err=0.
